muldiv_unit: RTL and testbench

- Iterative, parametrised multiply/divide unit that executes all eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles.
- Sits beside the ALU in the execute stage. It replaces single-cycle M-extension arithmetic with a start/busy/valid handshake that the hazard logic uses to stall fetch, decode and execute.
- Carries a destination-register tag so writeback can be matched to the issuing instruction.

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit using a start/busy/valid handshake.
//
// Multiplication is radix-2 shift-add and division is radix-2 restoring shift-subtract.
// Both work on operand magnitudes, and the sign is corrected in a final FIX cycle.
// Divide-by-zero and signed overflow are resolved when the operation is accepted.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   start    issue request, sampled only while busy=0
//   kill     abort the in-flight operation (pipeline flush)
//   op       funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   src_a    rs1 operand (multiplicand / dividend)
//   src_b    rs2 operand (multiplier / divisor)
//   tag_in   destination-register tag of the issuing instruction
//   busy     operation accepted and not yet completed
//   valid    one-cycle pulse when result and tag_out are valid
//   result   operation result, held until the next completion
//   tag_out  tag of the completed operation, held until the next completion
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   m_q;      // a_mag for multiply, b_mag (divisor) for divide
    logic [2*XLEN-1:0] acc_q;    // product, or {unused, dividend/quotient} for divide
    logic [XLEN-1:0]   rem_q;    // partial remainder; it never exceeds the divisor
    logic              a_neg_q, b_neg_q;
    logic [TAG_W-1:0]  tag_q;

    // ---------------- accept-time decode ----------------
    logic            accept, is_div, a_signed, b_signed, a_neg_in, b_neg_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;

    assign is_div   = op[2];
    assign a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    assign b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign a_neg_in = a_signed & src_a[XLEN-1];
    assign b_neg_in = b_signed & src_b[XLEN-1];
    assign a_mag_in = a_neg_in ? -src_a : src_a;
    assign b_mag_in = b_neg_in ? -src_b : src_b;

    assign div_zero = is_div & (src_b == '0);
    assign div_ovf  = is_div & ~op[0] & (src_a == MIN_NEG) & (src_b == '1);
    assign special  = div_zero | div_ovf;
    // op[1] selects remainder among divide ops
    assign special_res = div_zero ? (op[1] ? src_a : '1) : (op[1] ? '0 : src_a);

    // A new operation may be accepted in IDLE and also in DONE, which allows back-to-back issue.
    assign accept = start & ~kill & ((state_q == StIdle) | (state_q == StDone));

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;   // shifted partial remainder needs XLEN+1 bits
    logic              div_ok;
    logic [XLEN-1:0]   div_rem_next;
    logic [2*XLEN-1:0] div_acc_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    assign div_shift    = {rem_q, acc_q[XLEN-1]};
    assign div_diff     = div_shift - {1'b0, m_q};
    assign div_ok       = ~div_diff[XLEN];
    assign div_rem_next = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_acc_next = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ok};

    // ---------------- sign fix and output select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_raw, quo_fix, rem_fix, fix_res;

    assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    assign quo_raw  = acc_q[XLEN-1:0];
    assign quo_fix  = (a_neg_q ^ b_neg_q) ? -quo_raw : quo_raw;
    assign rem_fix  = a_neg_q ? -rem_q : rem_q;

    always_comb begin
        fix_res = '0;
        unique case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            3'b110, 3'b111:         fix_res = rem_fix;
            default:                fix_res = '0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        valid   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = special ? StDone : StCalc;
                end
            end
            StCalc: begin
                busy = 1'b1;
                if (kill) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                busy    = 1'b1;
                state_d = kill ? StIdle : StDone;
            end
            StDone: begin
                valid = 1'b1;
                if (accept) begin
                    state_d = special ? StDone : StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            op_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            tag_q   <= '0;
            result  <= '0;
            tag_out <= '0;
        end else if (accept) begin
            cnt_q   <= CW'(XLEN - 1);
            op_q    <= op;
            m_q     <= is_div ? b_mag_in : a_mag_in;
            acc_q   <= {{XLEN{1'b0}}, is_div ? a_mag_in : b_mag_in};
            rem_q   <= '0;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            tag_q   <= tag_in;
            if (special) begin
                result  <= special_res;
                tag_out <= tag_in;
            end
        end else if (state_q == StCalc) begin
            cnt_q <= cnt_q - 1'b1;
            if (op_q[2]) begin
                acc_q <= div_acc_next;
                rem_q <= div_rem_next;
            end else begin
                acc_q <= mul_next;
            end
        end else if (state_q == StFix && !kill) begin
            result  <= fix_res;
            tag_out <= tag_q;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, kill;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic [4:0]  tag_in;
    logic        busy, valid;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .tag_in  (tag_in),
        .busy    (busy),
        .valid   (valid),
        .result  (result),
        .tag_out (tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [63:0]     w;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'b000: begin up = ua * ub; w = up; return w[31:0]; end
            3'b001: begin sp = sa * sb; w = sp; return w[63:32]; end
            3'b010: begin sp = sa * longint'(ub); w = sp; return w[63:32]; end
            3'b011: begin up = ua * ub; w = up; return w[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                sp = sa / sb; w = sp; return w[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; w = up; return w[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                sp = sa % sb; w = sp; return w[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; w = up; return w[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if (o[2] && !o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Called at #1 after a rising edge; returns after the valid cycle has been sampled.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] res, output int lat,
                          output logic [4:0] tg, output logic bz);
        op = o; src_a = a; src_b = b; tag_in = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result; tg = tag_out; bz = busy;
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        logic [4:0]  tg, t;
        logic        bz;
        int          lat;
        t = 5'($urandom_range(1, 31));
        run_op(o, a, b, t, res, lat, tg, bz);
        check({name, " result"}, res, exp);
        check({name, " latency"}, lat, exp_lat);
        check({name, " tag"}, {27'b0, tg}, {27'b0, t});
        check({name, " busy@valid"}, {31'b0, bz}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] a, b, res;
        logic [2:0]  o;
        logic [4:0]  tg;
        logic        bz;
        int          lat, nvalid;

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0;
        src_a = '0; src_b = '0; tag_in = '0;

        vecs.push_back('{"MUL",     3'b000, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFE, 34});
        vecs.push_back('{"MULH",    3'b001, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFF, 34});
        vecs.push_back('{"MULHSU",  3'b010, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFF, 34});
        vecs.push_back('{"MULHU",   3'b011, 32'hFFFF_FFFF, 32'h2,          32'h0000_0001, 34});
        vecs.push_back('{"DIV",     3'b100, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD, 34});
        vecs.push_back('{"REM",     3'b110, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 34});
        vecs.push_back('{"DIVU",    3'b101, 32'd100,       32'd7,          32'd14,        34});
        vecs.push_back('{"REMU",    3'b111, 32'd100,       32'd7,          32'd2,         34});
        vecs.push_back('{"DIV0",    3'b100, 32'd5,         32'd0,          32'hFFFF_FFFF, 1});
        vecs.push_back('{"REM0",    3'b110, 32'd5,         32'd0,          32'd5,         1});
        vecs.push_back('{"DIVOVF",  3'b100, MIN_NEG,       32'hFFFF_FFFF,  MIN_NEG,       1});
        vecs.push_back('{"REMOVF",  3'b110, MIN_NEG,       32'hFFFF_FFFF,  32'd0,         1});
        vecs.push_back('{"MULHNEG", 3'b001, MIN_NEG,       MIN_NEG,        32'h4000_0000, 34});
        vecs.push_back('{"DIVUMAX", 3'b101, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 34});

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset valid", {31'b0, valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset tag_out", {27'b0, tag_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        foreach (vecs[i]) begin
            check_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a DIVU
        op = 3'b101; src_a = 32'd1000; src_b = 32'd3; tag_in = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset valid", {31'b0, valid}, 32'd0);
        check("midreset result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_op("postreset MUL", 3'b000, 32'd3, 32'd5, 32'd15, 34);
        @(posedge clk); #1;

        // start while busy is ignored; the special-case operands would complete quickly if taken
        op = 3'b000; src_a = 32'd6; src_b = 32'd7; tag_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        op = 3'b100; src_a = 32'd1; src_b = 32'd0;
        nvalid = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
        end
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        nvalid++;
        check("busy-start result", result, 32'd42);
        check("busy-start tag", {27'b0, tag_out}, 32'd9);
        // Start in the DONE cycle is accepted as a back-to-back issue
        run_op(3'b000, 32'h1234, 32'h10, 5'd3, res, lat, tg, bz);
        check("busy-start single valid", nvalid, 1);
        check("b2b result", res, 32'h12340);
        check("b2b latency", lat, 34);
        check("b2b tag", {27'b0, tg}, 32'd3);
        @(posedge clk); #1;
        check("valid one cycle", {31'b0, valid}, 32'd0);

        // start together with kill in IDLE is not accepted
        op = 3'b000; src_a = 32'd2; src_b = 32'd2; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("start+kill busy", {31'b0, busy}, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
        end
        check("start+kill no valid", nvalid, 0);

        // kill at cycle 5 of a MULHU
        op = 3'b011; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; tag_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill busy", {31'b0, busy}, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
        end
        check("kill no valid", nvalid, 0);
        check("kill result held", result, 32'h12340);
        check("kill tag held", {27'b0, tag_out}, 32'd3);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            check_op($sformatf("rand%0d op%0d", i, o), o, a, b, model(o, a, b),
                     model_lat(o, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
